seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 Parameter OUT_REG, default 1; 1 = registered single-cycle result, 0 = combinational single-cycle result (MUL always registered).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 a, b  input  XLEN each  operands.
REQ-008 alu_ctrl  input  5  opcode.
REQ-009 out_valid  output  1  result/flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  XLEN  operation result.
REQ-012 N, Z, C, V  output  1 each  negative, zero, carry, overflow flags.
REQ-013 busy  output  1  iterative multiply in progress.

Function
REQ-014 Opcodes: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLL, 00110 SRL, 00111 SRA, 01000 SLT (signed), 01001 SLTU, 01010 MUL (low XLEN bits of a*b), 01011 MULHU (high XLEN bits, unsigned).
REQ-015 Undefined opcodes: result 0, Z=1, N=C=V=0; still handshaken normally.
REQ-016 Shift amount = b[$clog2(XLEN)-1:0]; upper b bits ignored.
REQ-017 N = result[XLEN-1]; Z = (result == 0) for every op.
REQ-018 ADD: C = carry out of bit XLEN-1; V = signed overflow.
REQ-019 SUB: computed as a + ~b + 1; C = carry out (1 = no borrow, a >= b unsigned); V = signed overflow.
REQ-020 Logic, shift, SLT, SLTU, MUL, MULHU: C=0, V=0.
REQ-021 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-022 in_ready = (state == IDLE) && (!out_valid || out_ready) (OUT_REG=1); with OUT_REG=0, in_ready = out_ready in IDLE and combinational ops assert out_valid = in_valid in the same cycle.
REQ-023 Single-cycle ops (OUT_REG=1): result, flags, out_valid appear on the cycle after acceptance (latency 1); back-to-back throughput 1/cycle when out_ready=1.
REQ-024 FSM states IDLE, MUL, HOLD: IDLE -> MUL on accepted MUL/MULHU; MUL runs exactly XLEN cycles (shift-add, one multiplier bit per cycle); MUL -> HOLD after final iteration with out_valid=1; HOLD -> IDLE on out transfer.
REQ-025 MUL/MULHU latency: out_valid asserts XLEN+1 cycles after the accept edge; busy=1 in states MUL and HOLD.
REQ-026 in_ready = 0 during MUL and HOLD; in_valid ignored then.
REQ-027 out_valid held with result and flags stable until out transfer (no change while out_ready=0).
REQ-028 Operands for MUL are captured at acceptance; later changes of a, b, alu_ctrl do not affect the result.

Reset
REQ-029 rst_n low asynchronously forces state IDLE, out_valid=0, busy=0, result=0, N=0, Z=0, C=0, V=0, multiplier accumulator and counter cleared.
REQ-030 Reset during MUL or HOLD aborts the operation; no result is delivered; in_ready=1 on first clock edge after rst_n deasserts.

Structure
REQ-031 Package seq_alu_pkg holds opcode localparams, FSM state enum, and flag-index constants.
REQ-032 Iterative multiplier is sub-module seq_alu_mul (start, a, b, done, 2*XLEN product), parametrised by XLEN.

Verification
REQ-033 XLEN=32, a=F0000000, b=90000000, ADD -> result 80000000, N=1, Z=0, C=1, V=0, one cycle after accept.
REQ-034 Same operands, SUB -> result 60000000, N=0, Z=0, C=1, V=0.
REQ-035 a=00000419, b=00040004, MUL -> result 10641064, C=V=0, out_valid exactly 33 cycles after accept; in_ready=0 and busy=1 throughout.
REQ-036 a=00000000, b=00000000, SUB -> result 0, Z=1, C=1; opcode 11111 -> result 0, Z=1.
REQ-037 Backpressure: out_ready=0 for 5 cycles after ADD result -> result/flags stable, in_ready=0; out_ready=1 -> transfer, next op accepted same cycle.
REQ-038 Assert rst_n=0 mid-MUL (cycle 10) -> out_valid=0, busy=0 immediately; after release, ADD 1+1 -> result 2 with latency 1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
//   Shared definitions for the sequential ALU: opcode encodings, the control
//   FSM state type and the bit positions of the packed {N,Z,C,V} flag vector.
// -----------------------------------------------------------------------------
package seq_alu_pkg;

    // Opcode encodings carried on alu_ctrl.
    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_SLL   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_SLT   = 5'b01000;
    localparam logic [4:0] OP_SLTU  = 5'b01001;
    localparam logic [4:0] OP_MUL   = 5'b01010;
    localparam logic [4:0] OP_MULHU = 5'b01011;

    // Control FSM: IDLE handles single-cycle ops, MUL runs the iterative
    // multiplier, HOLD presents the product until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Bit positions inside the packed flag vector {N, Z, C, V}.
    localparam int FLAG_V    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_N    = 3;
    localparam int NUM_FLAGS = 4;

    // Opcodes that are routed to the iterative multiplier.
    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage : seq_alu_pkg

// File: rtl/seq_alu_mul.sv
// -----------------------------------------------------------------------------
// seq_alu_mul
//   Unsigned shift-add multiplier, one multiplier bit per clock.
//   A start pulse captures both operands; the product is ready XLEN cycles
//   later. done is high during the final iteration cycle, so the product
//   register holds the complete a*b from the following cycle on and stays
//   there until the next start.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (clears accumulator and counter)
//   start    load operands and begin a new multiplication
//   a, b     multiplicand / multiplier (XLEN bits)
//   done     final iteration in progress this cycle
//   product  2*XLEN-bit product register
// -----------------------------------------------------------------------------
module seq_alu_mul #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              done,
    output logic [2*XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] acc_q;     // {partial product, remaining multiplier bits}
    logic [CW-1:0]     count_q;
    logic              running_q;
    logic [XLEN:0]     partial;   // upper half plus addend, with carry

    // The multiplier sits in the low half of the accumulator; its LSB decides
    // whether the multiplicand is added before the whole thing shifts right.
    always_comb begin
        partial = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    end

    assign done    = running_q && (count_q == CW'(XLEN - 1));
    assign product = acc_q;

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            mcand_q   <= a;
            acc_q     <= {{XLEN{1'b0}}, b};
            count_q   <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            acc_q   <= {partial, acc_q[XLEN-1:1]};
            count_q <= count_q + 1'b1;
            if (done) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule : seq_alu_mul

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Sequential ALU with valid/ready handshakes on both sides. Single-cycle
//   ops (add/sub/logic/shift/compare) complete in one cycle, either through an
//   output register (OUT_REG=1) or combinationally (OUT_REG=0). MUL and MULHU
//   use the iterative multiplier and always deliver a registered result.
//
// Parameters
//   XLEN     datapath width (8, 16, 32 or 64)
//   OUT_REG  1: single-cycle results registered, 0: combinational
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operation handshake (transfer when both high)
//   a, b, alu_ctrl       operands and opcode
//   out_valid, out_ready result handshake (transfer when both high)
//   result               operation result
//   N, Z, C, V           negative, zero, carry, overflow flags
//   busy                 multiply in progress or waiting to be delivered
// -----------------------------------------------------------------------------
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit OUT_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      alu_ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            N,
    output logic            Z,
    output logic            C,
    output logic            V,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    // Pack flags into {N, Z, C, V}; N and Z always follow the result.
    function automatic logic [NUM_FLAGS-1:0] make_flags(
        input logic [XLEN-1:0] res,
        input logic            carry,
        input logic            ovf
    );
        logic [NUM_FLAGS-1:0] f;
        f         = '0;
        f[FLAG_N] = res[XLEN-1];
        f[FLAG_Z] = (res == '0);
        f[FLAG_C] = carry;
        f[FLAG_V] = ovf;
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [SHW-1:0]       shamt;
    logic [XLEN:0]        add_full;
    logic [XLEN:0]        sub_full;
    logic [XLEN-1:0]      alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic [NUM_FLAGS-1:0] alu_flags;

    always_comb begin
        shamt    = b[SHW-1:0];
        add_full = {1'b0, a} + {1'b0, b};
        // Subtraction as a + ~b + 1 so the carry out reads as "no borrow".
        sub_full = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        unique case (alu_ctrl)
            OP_ADD: begin
                alu_res = add_full[XLEN-1:0];
                alu_c   = add_full[XLEN];
                alu_v   = (a[XLEN-1] == b[XLEN-1]) && (alu_res[XLEN-1] != a[XLEN-1]);
            end
            OP_SUB: begin
                alu_res = sub_full[XLEN-1:0];
                alu_c   = sub_full[XLEN];
                alu_v   = (a[XLEN-1] != b[XLEN-1]) && (alu_res[XLEN-1] != a[XLEN-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            // Multiplies go to the iterative unit; undefined opcodes give 0.
            default: alu_res = '0;
        endcase
        alu_flags = make_flags(alu_res, alu_c, alu_v);
    end

    // ------------------------------------------------------------------
    // Iterative multiplier
    // ------------------------------------------------------------------
    logic              mul_start;
    logic              mul_done;
    logic [2*XLEN-1:0] mul_product;

    seq_alu_mul #(
        .XLEN (XLEN)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   is_mul;
    logic   accept;
    logic   ov_q;        // registered single-cycle result pending
    logic   hi_sel_q;    // MULHU: deliver the upper product half

    assign is_mul = is_mul_op(alu_ctrl);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        mul_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (OUT_REG) begin
                    in_ready  = !ov_q || out_ready;
                    out_valid = ov_q;
                end else begin
                    in_ready  = out_ready;
                    out_valid = in_valid && !is_mul;
                end
                accept = in_valid && in_ready;
                if (accept && is_mul) begin
                    mul_start = 1'b1;
                    state_d   = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (mul_done) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [XLEN-1:0]      res_q;
    logic [NUM_FLAGS-1:0] flags_q;

    // NOTE: result and flags are datapath registers but are still reset,
    // because they are visible on the ports straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q     <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
            hi_sel_q <= 1'b0;
        end else if (accept && is_mul) begin
            hi_sel_q <= (alu_ctrl == OP_MULHU);
            ov_q     <= 1'b0;
        end else if (accept && OUT_REG) begin
            ov_q    <= 1'b1;
            res_q   <= alu_res;
            flags_q <= alu_flags;
        end else if (out_ready) begin
            ov_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Result selection
    // ------------------------------------------------------------------
    logic [XLEN-1:0]      mul_res;
    logic [NUM_FLAGS-1:0] out_flags;

    always_comb begin
        mul_res   = hi_sel_q ? mul_product[2*XLEN-1:XLEN] : mul_product[XLEN-1:0];
        result    = res_q;
        out_flags = flags_q;
        if (state_q == HOLD) begin
            // The product register is frozen in HOLD, so no extra storage.
            result    = mul_res;
            out_flags = make_flags(mul_res, 1'b0, 1'b0);
        end else if (!OUT_REG && state_q == IDLE) begin
            result    = alu_res;
            out_flags = alu_flags;
        end
    end

    assign N = out_flags[FLAG_N];
    assign Z = out_flags[FLAG_Z];
    assign C = out_flags[FLAG_C];
    assign V = out_flags[FLAG_V];

endmodule : seq_alu
